// File: rtl/irq_nios2_qsys_oci_dct_packer_pkg.sv
// rtl/irq_nios2_qsys_oci_dct_packer_pkg.sv - shared OCI trace packer constants
package irq_nios2_qsys_oci_dct_packer_pkg;

    localparam int OCI_FRAG_W    = 2;
    localparam int OCI_NUM_FRAGS = 15;
    localparam int OCI_DCT_BUF_W = 30;
    localparam int OCI_COUNT_W   = 4;

endpackage

// File: rtl/irq_nios2_qsys_oci_dct_packer_if.sv
// rtl/irq_nios2_qsys_oci_dct_packer_if.sv - fragment input / packed word output bundle
interface irq_nios2_qsys_oci_dct_packer_if
    import irq_nios2_qsys_oci_dct_packer_pkg::*;
#(
    parameter int FRAG_W = OCI_FRAG_W
) ();

    logic                     in_valid;
    logic [FRAG_W-1:0]        in_frag;
    logic                     in_ready;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [OCI_DCT_BUF_W-1:0] dct_buffer;
    logic [OCI_COUNT_W-1:0]   dct_count;
    logic                     test_ending;
    logic                     test_has_ended;

    modport master (
        output in_valid, in_frag, flush, out_ready,
        input  in_ready, out_valid, dct_buffer, dct_count, test_ending, test_has_ended
    );

    modport slave (
        input  in_valid, in_frag, flush, out_ready,
        output in_ready, out_valid, dct_buffer, dct_count, test_ending, test_has_ended
    );

endinterface

// File: rtl/irq_nios2_qsys_oci_dct_packer.sv
// rtl/irq_nios2_qsys_oci_dct_packer.sv - packs trace fragments into 30-bit words, handles end-of-test flush
module irq_nios2_qsys_oci_dct_packer
    import irq_nios2_qsys_oci_dct_packer_pkg::*;
#(
    parameter int FRAG_W    = OCI_FRAG_W,
    parameter int NUM_FRAGS = OCI_NUM_FRAGS
) (
    input  logic                                 clk,
    input  logic                                 reset,
    irq_nios2_qsys_oci_dct_packer_if.slave       bus
);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;
    localparam logic [OCI_COUNT_W-1:0] COUNT_ONE  = OCI_COUNT_W'(1);
    localparam logic [OCI_COUNT_W-1:0] COUNT_FULL = OCI_COUNT_W'(NUM_FRAGS);

    logic [0:0]               state;
    logic                     flush_tag;
    logic                     accept;
    logic                     word_done;
    logic                     flush_nonempty;
    logic [OCI_COUNT_W-1:0]   count_inc;
    logic [OCI_DCT_BUF_W-1:0] buf_shift;

    assign bus.in_ready   = (state == ST_FILL) && !reset;
    assign accept         = bus.in_valid && bus.in_ready;
    assign count_inc      = bus.dct_count + COUNT_ONE;
    assign buf_shift      = {bus.dct_buffer[OCI_DCT_BUF_W-FRAG_W-1:0], bus.in_frag};
    assign word_done      = bus.out_valid && bus.out_ready;
    // a fragment arriving with the flush is packed first, so it counts toward "non-empty"
    assign flush_nonempty = bus.flush && (accept || (bus.dct_count != '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_FILL;
            flush_tag          <= 1'b0;
            bus.dct_buffer     <= '0;
            bus.dct_count      <= '0;
            bus.out_valid      <= 1'b0;
            bus.test_ending    <= 1'b0;
            bus.test_has_ended <= 1'b0;
        end else begin
            bus.test_ending <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        bus.dct_buffer <= buf_shift;
                        bus.dct_count  <= count_inc;
                    end
                    if ((accept && (count_inc == COUNT_FULL)) || flush_nonempty) begin
                        state         <= ST_EMIT;
                        bus.out_valid <= 1'b1;
                    end
                    if (flush_nonempty) begin
                        flush_tag <= 1'b1;
                    end else if (bus.flush) begin
                        bus.test_ending    <= 1'b1;
                        bus.test_has_ended <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (word_done) begin
                        state          <= ST_FILL;
                        bus.out_valid  <= 1'b0;
                        bus.dct_buffer <= '0;
                        bus.dct_count  <= '0;
                        flush_tag      <= 1'b0;
                        // a flush landing on the handshake cycle still tags the departing word
                        if (flush_tag || bus.flush) begin
                            bus.test_ending    <= 1'b1;
                            bus.test_has_ended <= 1'b1;
                        end
                    end else if (bus.flush) begin
                        flush_tag <= 1'b1;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_nios2_qsys_oci_dct_packer.sv
// tb/tb_irq_nios2_qsys_oci_dct_packer.sv - self-checking bench for the OCI trace packer
module tb_irq_nios2_qsys_oci_dct_packer;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    logic exp_he;

    irq_nios2_qsys_oci_dct_packer_if bus ();

    irq_nios2_qsys_oci_dct_packer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [29:0] frags;    // fragment i fed from bits [2i+1:2i]
        int          fmode;    // 0 none, 1 flush after last, 2 flush with last
        logic [3:0]  exp_cnt;
        logic [29:0] exp_buf;
        logic        exp_end;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [1:0] frag, input logic with_flush);
        chk("in_ready_before_feed", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_frag  = frag;
        bus.flush    = with_flush;
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        for (int i = 0; i < v.n; i++) begin
            feed(v.frags[2*i +: 2], (v.fmode == 2) && (i == v.n - 1));
        end
        if (v.fmode == 1) begin
            bus.flush = 1'b1;
            tick();
            bus.flush = 1'b0;
        end
        chk($sformatf("v%0d_out_valid", idx), 32'(bus.out_valid), 32'd1);
        chk($sformatf("v%0d_count", idx), 32'(bus.dct_count), 32'(v.exp_cnt));
        chk($sformatf("v%0d_buffer", idx), 32'(bus.dct_buffer), 32'(v.exp_buf));
        chk($sformatf("v%0d_in_ready_emit", idx), 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        if (v.exp_end) exp_he = 1'b1;
        chk($sformatf("v%0d_out_valid_after", idx), 32'(bus.out_valid), 32'd0);
        chk($sformatf("v%0d_count_after", idx), 32'(bus.dct_count), 32'd0);
        chk($sformatf("v%0d_in_ready_after", idx), 32'(bus.in_ready), 32'd1);
        chk($sformatf("v%0d_test_ending", idx), 32'(bus.test_ending), 32'(v.exp_end));
        chk($sformatf("v%0d_has_ended", idx), 32'(bus.test_has_ended), 32'(exp_he));
        tick();
        chk($sformatf("v%0d_test_ending_drop", idx), 32'(bus.test_ending), 32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_he = 1'b0;

        vecs[0] = '{15, 30'h15555555, 0, 4'd15, 30'h15555555, 1'b0};
        vecs[1] = '{3,  30'h23,       1, 4'd3,  30'h32,       1'b1};
        vecs[2] = '{1,  30'h2,        2, 4'd1,  30'h2,        1'b1};
        vecs[3] = '{15, 30'h3,        0, 4'd15, 30'h30000000, 1'b0};
        vecs[4] = '{5,  30'h139,      1, 4'd5,  30'h1B1,      1'b1};

        bus.in_valid  = 1'b1;
        bus.in_frag   = 2'b11;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.dct_count), 32'd0);
        chk("rst_buffer", 32'(bus.dct_buffer), 32'd0);
        chk("rst_test_ending", 32'(bus.test_ending), 32'd0);
        chk("rst_has_ended", 32'(bus.test_has_ended), 32'd0);
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        tick();
        chk("post_rst_count", 32'(bus.dct_count), 32'd0);

        run_vec(vecs[0], 0);

        // flush on an empty buffer: no word, end-of-test pulse next cycle
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        exp_he = 1'b1;
        chk("empty_flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("empty_flush_test_ending", 32'(bus.test_ending), 32'd1);
        chk("empty_flush_has_ended", 32'(bus.test_has_ended), 32'd1);
        chk("empty_flush_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("empty_flush_te_drop", 32'(bus.test_ending), 32'd0);
        chk("empty_flush_no_word", 32'(bus.out_valid), 32'd0);

        for (int k = 1; k < 5; k++) run_vec(vecs[k], k);

        // backpressure on a full word while the producer keeps pushing
        for (int i = 0; i < 15; i++) feed(2'b10, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_frag  = 2'b01;
        chk("bp_out_valid_first", 32'(bus.out_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp%0d_out_valid", c), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp%0d_count", c), 32'(bus.dct_count), 32'd15);
            chk($sformatf("bp%0d_buffer", c), 32'(bus.dct_buffer), 32'h2AAAAAAA);
            chk($sformatf("bp%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("bp_done_count", 32'(bus.dct_count), 32'd0);
        chk("bp_done_buffer", 32'(bus.dct_buffer), 32'd0);
        chk("bp_done_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_done_test_ending", 32'(bus.test_ending), 32'd0);

        // reset while a flush-tagged word is pending
        for (int i = 0; i < 3; i++) feed(2'b01, 1'b0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("rm_out_valid_pending", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        tick();
        exp_he = 1'b0;
        chk("rm_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rm_count", 32'(bus.dct_count), 32'd0);
        chk("rm_buffer", 32'(bus.dct_buffer), 32'd0);
        chk("rm_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rm_test_ending", 32'(bus.test_ending), 32'd0);
        chk("rm_has_ended", 32'(bus.test_has_ended), 32'd0);
        reset = 1'b0;
        tick();
        chk("rm_test_ending_after", 32'(bus.test_ending), 32'd0);
        chk("rm_out_valid_after", 32'(bus.out_valid), 32'd0);
        feed(2'b11, 1'b0);
        chk("rm_first_count", 32'(bus.dct_count), 32'd1);
        chk("rm_first_buffer", 32'(bus.dct_buffer), 32'd3);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("rm_flush_out_valid", 32'(bus.out_valid), 32'd1);
        chk("rm_flush_count", 32'(bus.dct_count), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("rm_final_test_ending", 32'(bus.test_ending), 32'd1);
        chk("rm_final_has_ended", 32'(bus.test_has_ended), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
